// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, polarity encodings and a small window helper
// for the timing generator.
package vga_timing_pkg;

    localparam logic POL_NEG = 1'b0;
    localparam logic POL_POS = 1'b1;

    typedef struct packed {
        int unsigned disp;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
        logic        pol;
    } axis_timing_t;

    localparam axis_timing_t VGA640_H = '{640, 16,  96, 48, POL_NEG};
    localparam axis_timing_t VGA640_V = '{480, 10,   2, 33, POL_NEG};
    localparam axis_timing_t VGA800_H = '{800, 40, 128, 88, POL_POS};
    localparam axis_timing_t VGA800_V = '{600,  1,   4, 23, POL_POS};

    function automatic logic in_window(int unsigned pos, int unsigned lo, int unsigned len);
        return (pos >= lo) && (pos < lo + len);
    endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-rate strobe: one registered clk-wide pulse every CLK_DIV cycles while en=1.
module vga_pix_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic p_tick
);
    localparam int unsigned DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          tick_q, tick_d;

    always_comb begin
        div_d  = div_q;
        tick_d = 1'b0;
        if (en) begin
            tick_d = (div_q == LAST);
            div_d  = (div_q == LAST) ? '0 : div_q + DW'(1);
        end else if (tick_q) begin
            // A strobe cut off by en falling is re-armed so its pixel is not lost.
            div_d = LAST;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign p_tick = tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync,
// blanking and start-of-line/frame strobes aligned to the counters.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_DISP  = 640,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned V_DISP  = 480,
    parameter int unsigned V_FP    = 10,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 33,
    parameter bit          HS_POL  = POL_NEG,
    parameter bit          VS_POL  = POL_NEG,
    parameter int unsigned CLK_DIV = 4,
    localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP,
    localparam int unsigned X_W     = $clog2(H_TOTAL),
    localparam int unsigned Y_W     = $clog2(V_TOTAL)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    output logic           p_tick,
    output logic           hsync,
    output logic           vsync,
    output logic           video_on,
    output logic [X_W-1:0] x_pos,
    output logic [Y_W-1:0] y_pos,
    output logic           line_start,
    output logic           frame_start
);
    generate
        if (CLK_DIV < 1 || CLK_DIV > 16 || H_DISP == 0 || H_FP == 0 || H_SYNC == 0 ||
            H_BP == 0 || V_DISP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_param
            $error("vga_timing_gen: illegal parameter set");
        end
    endgenerate

    logic           adv, x_wrap, y_wrap;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           hs_q, hs_d, vs_q, vs_d, vid_q, vid_d, ls_q, ls_d, fs_q, fs_d;

    vga_pix_tick #(.CLK_DIV(CLK_DIV)) u_pix_tick (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .p_tick (p_tick)
    );

    assign adv    = p_tick & en;
    assign x_wrap = (x_q == X_W'(H_TOTAL - 1));
    assign y_wrap = (y_q == Y_W'(V_TOTAL - 1));

    // Sync/blank/strobes are derived from the next counts so they land with them.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (adv) begin
            x_d = x_wrap ? '0 : x_q + X_W'(1);
            if (x_wrap) y_d = y_wrap ? '0 : y_q + Y_W'(1);
        end
        hs_d  = in_window(32'(x_d), H_DISP + H_FP, H_SYNC) ? HS_POL : ~HS_POL;
        vs_d  = in_window(32'(y_d), V_DISP + V_FP, V_SYNC) ? VS_POL : ~VS_POL;
        vid_d = (32'(x_d) < H_DISP) && (32'(y_d) < V_DISP);
        ls_d  = adv && x_wrap;
        fs_d  = adv && x_wrap && y_wrap;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q   <= '0;
            y_q   <= '0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            vid_q <= 1'b0;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
            if (en) begin
                hs_q  <= hs_d;
                vs_q  <= vs_d;
                vid_q <= vid_d;
            end
        end
    end

    assign x_pos       = x_q;
    assign y_pos       = y_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign video_on    = vid_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a scaled-down raster (24x13) so whole
// frames fit in a short run; instance b covers CLK_DIV=1 with positive syncs.
module tb_vga_timing_gen;
    localparam int HD = 16, HF = 2, HSW = 3, HB = 3, HT = HD + HF + HSW + HB;  // 24
    localparam int VD = 8,  VF = 1, VSW = 2, VB = 2, VT = VD + VF + VSW + VB;  // 13
    localparam int DIV = 4;
    localparam int LINE_CLK  = HT * DIV;        // 96
    localparam int FRAME_CLK = LINE_CLK * VT;   // 1248

    logic gclk = 1'b0, grst_n = 1'b1, en = 1'b1, en_b = 1'b1;
    logic       a_tick, a_hs, a_vs, a_vid, a_ls, a_fs;
    logic [4:0] a_x;
    logic [3:0] a_y;
    logic       b_tick, b_hs, b_vs, b_vid, b_ls, b_fs;
    logic [4:0] b_x;
    logic [3:0] b_y;

    int n_chk = 0, n_pass = 0;
    int mx = 0, my = 0, bx = 0, by = 0;
    logic m_tick = 1'b0, bm_tick = 1'b0;
    int err_a_pos = 0, err_a_sync = 0, err_a_vid = 0, err_a_pulse = 0;
    int err_b_pos = 0, err_b_sync = 0, err_b_pulse = 0;

    always #5 gclk = ~gclk;

    vga_timing_gen #(.H_DISP(HD), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
                     .V_DISP(VD), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
                     .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(DIV)) dut_a (
        .clk(gclk), .reset(grst_n), .en(en), .p_tick(a_tick), .hsync(a_hs), .vsync(a_vs),
        .video_on(a_vid), .x_pos(a_x), .y_pos(a_y), .line_start(a_ls), .frame_start(a_fs));

    vga_timing_gen #(.H_DISP(HD), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
                     .V_DISP(VD), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
                     .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1)) dut_b (
        .clk(gclk), .reset(grst_n), .en(en_b), .p_tick(b_tick), .hsync(b_hs), .vsync(b_vs),
        .video_on(b_vid), .x_pos(b_x), .y_pos(b_y), .line_start(b_ls), .frame_start(b_fs));

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    endtask

    function automatic int in_hs(input int x);
        return int'(x >= HD + HF && x < HD + HF + HSW);
    endfunction

    function automatic int in_vs(input int y);
        return int'(y >= VD + VF && y < VD + VF + VSW);
    endfunction

    // Advance one clk, then update the reference raster and tally disagreements.
    task automatic step();
        logic adv, badv;
        int   exp_ls, exp_fs;
        @(negedge gclk);
        if (!grst_n) begin
            mx = 0; my = 0; m_tick = 1'b0;
            bx = 0; by = 0; bm_tick = 1'b0;
        end else begin
            adv = m_tick && en;
            if (adv) begin
                mx = (mx == HT - 1) ? 0 : mx + 1;
                if (mx == 0) my = (my == VT - 1) ? 0 : my + 1;
            end
            if (int'(a_x) != mx || int'(a_y) != my) err_a_pos++;
            if (int'(a_hs) != 1 - in_hs(mx) || int'(a_vs) != 1 - in_vs(my)) err_a_sync++;
            if (int'(a_vid) != int'(mx < HD && my < VD)) err_a_vid++;
            exp_ls = int'(adv && mx == 0);
            exp_fs = int'(adv && mx == 0 && my == 0);
            if (int'(a_ls) != exp_ls || int'(a_fs) != exp_fs) err_a_pulse++;
            m_tick = a_tick;

            badv = bm_tick && en_b;
            if (badv) begin
                bx = (bx == HT - 1) ? 0 : bx + 1;
                if (bx == 0) by = (by == VT - 1) ? 0 : by + 1;
            end
            if (int'(b_x) != bx || int'(b_y) != by) err_b_pos++;
            if (int'(b_hs) != in_hs(bx) || int'(b_vs) != in_vs(by)) err_b_sync++;
            exp_ls = int'(badv && bx == 0);
            exp_fs = int'(badv && bx == 0 && by == 0);
            if (int'(b_ls) != exp_ls || int'(b_fs) != exp_fs) err_b_pulse++;
            bm_tick = b_tick;
        end
    endtask

    initial begin
        int ka, kb, fs1, fs2, ls_cnt, vid_ticks, hs_low_clk, xmax, ymax;
        int hxmin, hxmax, vymin, vymax, fs_no_ls, bls1, bls2, b_tick_low;
        int bhxmin, bhxmax, bvymin, bvymax, found, cyc, ticks, hold_err, dropped, ls1;
        logic h0, v0, vid0;
        logic [3:0] y0;

        // Reset must act without any clk edge.
        #2 grst_n = 1'b0;
        #1;
        chk("rst_x", int'(a_x), 0);
        chk("rst_y", int'(a_y), 0);
        chk("rst_tick", int'(a_tick), 0);
        chk("rst_hs", int'(a_hs), 1);
        chk("rst_vs", int'(a_vs), 1);
        chk("rst_vid", int'(a_vid), 0);
        chk("rst_ls", int'(a_ls), 0);
        chk("rst_fs", int'(a_fs), 0);
        chk("rst_b_hs", int'(b_hs), 0);
        chk("rst_b_vs", int'(b_vs), 0);
        repeat (3) step();
        chk("rst_hold_tick", int'(a_tick), 0);

        grst_n = 1'b1;   // edge 1 is the next posedge
        ka = 0; kb = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (a_tick && ka == 0) ka = i;
            if (b_tick && kb == 0) kb = i;
        end
        chk("first_tick_edge", ka, DIV);
        chk("b_first_tick_edge", kb, 1);

        fs1 = 0; fs2 = 0; ls_cnt = 0; vid_ticks = 0; hs_low_clk = 0; xmax = 0; ymax = 0;
        hxmin = 999; hxmax = 0; vymin = 999; vymax = 0; fs_no_ls = 0;
        bls1 = 0; bls2 = 0; b_tick_low = 0; bhxmin = 999; bhxmax = 0; bvymin = 999; bvymax = 0;
        for (int k = 9; k <= 2600; k++) begin
            step();
            if (a_fs) begin
                if (fs1 == 0) fs1 = k;
                else if (fs2 == 0) fs2 = k;
            end
            if (fs1 != 0 && fs2 == 0) begin
                if (a_ls) ls_cnt++;
                if (a_tick && a_vid) vid_ticks++;
                if (!a_hs) begin
                    hs_low_clk++;
                    if (int'(a_x) < hxmin) hxmin = int'(a_x);
                    if (int'(a_x) > hxmax) hxmax = int'(a_x);
                end
                if (!a_vs) begin
                    if (int'(a_y) < vymin) vymin = int'(a_y);
                    if (int'(a_y) > vymax) vymax = int'(a_y);
                end
                if (int'(a_x) > xmax) xmax = int'(a_x);
                if (int'(a_y) > ymax) ymax = int'(a_y);
            end
            if (a_fs && !a_ls) fs_no_ls++;
            if (b_ls) begin
                if (bls1 == 0) bls1 = k;
                else if (bls2 == 0) bls2 = k;
            end
            if (!b_tick) b_tick_low++;
            if (b_hs) begin
                if (int'(b_x) < bhxmin) bhxmin = int'(b_x);
                if (int'(b_x) > bhxmax) bhxmax = int'(b_x);
            end
            if (b_vs) begin
                if (int'(b_y) < bvymin) bvymin = int'(b_y);
                if (int'(b_y) > bvymax) bvymax = int'(b_y);
            end
        end
        // Pixel (0,0) lasts until the 312th advance, at edge 4*312+1.
        chk("first_fs_edge", fs1, FRAME_CLK + 1);
        chk("frame_period", fs2 - fs1, FRAME_CLK);
        chk("ls_per_frame", ls_cnt, VT);
        chk("vid_ticks", vid_ticks, HD * VD);
        chk("hs_low_clk", hs_low_clk, HSW * DIV * VT);
        chk("x_max", xmax, HT - 1);
        chk("y_max", ymax, VT - 1);
        chk("hs_low_xmin", hxmin, HD + HF);
        chk("hs_low_xmax", hxmax, HD + HF + HSW - 1);
        chk("vs_low_ymin", vymin, VD + VF);
        chk("vs_low_ymax", vymax, VD + VF + VSW - 1);
        chk("fs_without_ls", fs_no_ls, 0);
        chk("b_line_period", bls2 - bls1, HT);
        chk("b_tick_low", b_tick_low, 0);
        chk("b_hs_high_xmin", bhxmin, HD + HF);
        chk("b_hs_high_xmax", bhxmax, HD + HF + HSW - 1);
        chk("b_vs_high_ymin", bvymin, VD + VF);
        chk("b_vs_high_ymax", bvymax, VD + VF + VSW - 1);

        // Drop en for 37 clk on the last visible pixel of a line.
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            step();
            if (a_ls) found = 1;
        end
        chk("en_find_ls", found, 1);
        cyc = 0; ticks = 0; hold_err = 0; dropped = 0; found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            step();
            cyc++;
            if (a_ls) found = 1;
            else begin
                if (a_tick) ticks++;
                if (int'(a_x) == HD - 1 && dropped == 0) begin
                    dropped = 1;
                    h0 = a_hs; v0 = a_vs; vid0 = a_vid; y0 = a_y;
                    en = 1'b0;
                    repeat (37) begin
                        step();
                        cyc++;
                        if (int'(a_x) != HD - 1 || a_y != y0 || a_tick || a_ls || a_fs ||
                            a_hs != h0 || a_vs != v0 || a_vid != vid0) hold_err++;
                    end
                    en = 1'b1;
                end
            end
        end
        chk("en_dropped", dropped, 1);
        chk("en_hold_err", hold_err, 0);
        chk("en_line_clk", cyc, LINE_CLK + 37);
        chk("en_line_ticks", ticks, HT);

        // Reset in the middle of a frame.
        found = 0;
        for (int i = 0; i < 1500 && found == 0; i++) begin
            step();
            if (int'(a_y) == 5) found = 1;
        end
        chk("rst_find_y", found, 1);
        grst_n = 1'b0;
        #1;
        chk("mid_rst_xy", int'({a_x, a_y}), 0);
        chk("mid_rst_tick_ls_fs", int'({a_tick, a_ls, a_fs}), 0);
        chk("mid_rst_hs_vs_vid", int'({a_hs, a_vs, a_vid}), 3'b110);
        chk("mid_rst_b_hs_vs", int'({b_hs, b_vs}), 0);
        repeat (4) step();
        grst_n = 1'b1;
        ls1 = 0; fs1 = 0;
        for (int k = 1; k <= 1300 && fs1 == 0; k++) begin
            step();
            if (a_ls && ls1 == 0) ls1 = k;
            if (a_fs) fs1 = k;
        end
        chk("rst_first_ls_edge", ls1, LINE_CLK + 1);
        chk("rst_first_fs_edge", fs1, FRAME_CLK + 1);

        chk("a_pos_model", err_a_pos, 0);
        chk("a_sync_model", err_a_sync, 0);
        chk("a_vid_model", err_a_vid, 0);
        chk("a_pulse_model", err_a_pulse, 0);
        chk("b_pos_model", err_b_pos, 0);
        chk("b_sync_model", err_b_sync, 0);
        chk("b_pulse_model", err_b_pulse, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_DISP, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48, meaning horizontal front porch, sync and back porch widths in pixels.
REQ-003 SHALL have parameter V_DISP, default 480, meaning visible lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33, meaning vertical front porch, sync and back porch widths in lines.
REQ-005 SHALL have parameters HS_POL and VS_POL, defaults 0 and 0, meaning active sync level (0 = active-low).
REQ-006 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per pixel (1..16).
REQ-007 SHALL have ports clk, input, 1, system clock; all logic in this single domain.
REQ-008 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port en, input, 1, run enable; low freezes all state.
REQ-010 SHALL have ports p_tick, hsync, vsync and video_on, each output, 1 bit: pixel strobe, horizontal sync, vertical sync and visible region.
REQ-011 SHALL have ports x_pos and y_pos, outputs, X_W and Y_W bits: current pixel column and line.
REQ-012 SHALL have ports line_start and frame_start, outputs, 1 bit each: one-clk pulses.

Function
REQ-013 H_TOTAL SHALL be H_DISP+H_FP+H_SYNC+H_BP, and V_TOTAL SHALL be V_DISP+V_FP+V_SYNC+V_BP.
REQ-014 X_W SHALL be clog2(H_TOTAL) and Y_W SHALL be clog2(V_TOTAL); elaboration SHALL fail when CLK_DIV<1, when CLK_DIV>16, or when any width parameter is 0.
REQ-015 A divider counter SHALL count 0..CLK_DIV-1 on clk while en=1, then wrap to 0.
REQ-016 p_tick SHALL be registered and high for exactly one clk cycle in every CLK_DIV cycles; it SHALL be constantly high while en=1 when CLK_DIV=1.
REQ-017 The first p_tick after reset release with en=1 SHALL occur on the CLK_DIV-th rising edge.
REQ-018 x_pos SHALL advance on the clk edge after a p_tick cycle and SHALL wrap from H_TOTAL-1 to 0.
REQ-019 y_pos SHALL advance only when x_pos wraps, and SHALL wrap from V_TOTAL-1 to 0 on the same edge.
REQ-020 Line order SHALL be display, front porch, sync, back porch; the same order SHALL apply to frames.
REQ-021 hsync SHALL be at HS_POL level when x_pos is in [H_DISP+H_FP, H_DISP+H_FP+H_SYNC-1] and inverse otherwise; vsync SHALL follow the same rule on y_pos with VS_POL.
REQ-022 video_on SHALL be 1 iff x_pos<H_DISP and y_pos<V_DISP.
REQ-023 hsync, vsync, video_on, line_start and frame_start SHALL be registered and computed from next-count values, so they align with x_pos/y_pos on the same cycle (zero relative skew).
REQ-024 line_start SHALL pulse for one clk on the cycle in which x_pos first equals 0 after a wrap.
REQ-025 frame_start SHALL pulse on the cycle in which (x_pos,y_pos) first equals (0,0) after a wrap; it SHALL coincide with a line_start pulse.
REQ-026 With en=0, counters and the divider SHALL hold, p_tick, line_start and frame_start SHALL be 0, and sync/video_on SHALL hold their values.
REQ-027 When en rises again, counting SHALL resume from the held divider value, with no pixel lost or duplicated.

Reset
REQ-028 On reset low, without waiting for clk: divider=0, x_pos=0, y_pos=0, p_tick=0, line_start=0, frame_start=0, video_on=0, hsync=~HS_POL, vsync=~VS_POL.
REQ-029 Reset asserted mid-frame SHALL restart timing at (0,0); no start pulse SHALL be issued for the reset itself.
REQ-030 Reset release SHALL be synchronised externally; the block SHALL NOT contain a reset synchroniser.

Structure
REQ-031 Package vga_timing_pkg SHALL hold 640x480@60 and 800x600@60 timing constant sets and the polarity encodings.
REQ-032 The divider SHALL be sub-module vga_pix_tick (parameter CLK_DIV; ports clk, reset, en, p_tick).
REQ-033 There SHALL be no derived or gated clocks; every flop SHALL be clocked by clk and use p_tick as an enable.

Verification
REQ-034 Defaults, en=1, run one frame -> exactly 1,680,000 clk cycles between frame_start pulses, and 525 line_start pulses per frame.
REQ-035 Defaults -> hsync low exactly for x_pos 656..751 (96 pixels, 384 clk); vsync low exactly for y_pos 490..491.
REQ-036 Defaults -> video_on high for exactly 307,200 p_tick cycles per frame; x_pos max 799, y_pos max 524.
REQ-037 CLK_DIV=1, HS_POL=1, VS_POL=1 -> p_tick constant 1; hsync high for x_pos 656..751; line period 800 clk.
REQ-038 Drop en for 37 clk at x_pos=639 -> counters hold, no pulses, and the line length resumes with exactly 800 pixels.
REQ-039 Assert reset at y_pos=300 -> all outputs at REQ-028 values immediately; the first frame_start comes 1,680,000 clk after release.
